if_fetch_stage: RTL and testbench

//  - Instruction-fetch stage; produces the {PC, instruction} pair consumed by the decode stage.
//  - Issues in-order word fetches to instruction memory over a req/ready + rvalid bus.
//  - Buffers returned words in a small prefetch FIFO.
//  - Honours the decode-stage hazard freeze.
//  - Redirects and flushes on a taken branch from execute.

---
 rtl/if_pkg.sv | 22 ++
 rtl/if_fetch_fifo.sv | 58 +++++
 rtl/if_fetch_stage.sv | 188 ++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The top's optional redirect bypass is controlled by IF_BRANCH_BYPASS_EN.
package if_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] BUBBLE_INSTR_DEF = 32'hF000_0000;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } if_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } if_state_t;

   function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] addr);
      return addr + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Prefetch FIFO of {pc, instruction} entries with push/pop/flush and occupancy count.
// The head entry is read combinationally so a pushed word can be popped the following cycle.
module if_fetch_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  if_entry_t                din,
   output if_entry_t                dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if_entry_t        mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   assign dout  = mem[rd_ptr_reg];
   assign count = count_reg;

   push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && !flush && count_reg == CW'(DEPTH)));

   pop_when_empty: assert property (@(posedge clk) disable iff (rst)
      !(pop && !flush && count_reg == '0));

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: credit-limited in-order fetch, prefetch FIFO, freeze and branch redirect.
// Define IF_BRANCH_BYPASS_EN to issue the branch target in the redirect cycle itself.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter int                DEPTH        = 2,
   parameter logic [WORD_W-1:0] RESET_PC     = 32'h0000_0000,
   parameter logic [WORD_W-1:0] BUBBLE_INSTR = BUBBLE_INSTR_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_addr,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] instruction,
   output logic              valid
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = CW + 1;

   logic [WORD_W-1:0] fetch_pc_reg;
   logic [WORD_W-1:0] fetch_pc_next;
   logic [WORD_W-1:0] resp_pc_reg;
   logic [WORD_W-1:0] resp_pc_next;
   logic [CW-1:0]     in_flight_reg;
   logic [CW-1:0]     in_flight_next;
   logic [CW-1:0]     discard_reg;
   logic [CW-1:0]     discard_next;
   logic [CW-1:0]     discard_on_branch;
   if_state_t         state_reg;
   if_state_t         state_next;

   logic              valid_reg;
   logic [WORD_W-1:0] pc_reg;
   logic [WORD_W-1:0] instr_reg;

   logic [CW-1:0]     fifo_count;
   if_entry_t         fifo_head;
   if_entry_t         fifo_din;
   logic              accept;
   logic              pop;
   logic              push;
   logic              drop;
   logic              credit_ok;
   logic [OW-1:0]     occupancy;

   assign pop = (!valid_reg || !freeze) && (fifo_count != '0);

   // The entry popped this cycle frees its slot immediately; without this a 1-cycle
   // memory could only sustain one instruction every other cycle at DEPTH=2.
   assign occupancy = OW'(fifo_count) + OW'(in_flight_reg) - OW'(pop);
   assign credit_ok = occupancy < OW'(DEPTH);

`ifdef IF_BRANCH_BYPASS_EN
   assign imem_req  = !rst && credit_ok;
   assign imem_addr = branch_taken ? branch_addr : fetch_pc_reg;
`else
   assign imem_req  = !rst && credit_ok && !branch_taken;
   assign imem_addr = fetch_pc_reg;
`endif

   assign accept = imem_req && imem_ready;

   always_comb begin
      in_flight_next = in_flight_reg + CW'(accept) - CW'(imem_rvalid);
`ifdef IF_BRANCH_BYPASS_EN
      // The target request accepted in the branch cycle belongs to the new path.
      discard_on_branch = in_flight_next - CW'(accept);
      fetch_pc_next     = accept ? next_word(imem_addr) : imem_addr;
`else
      discard_on_branch = in_flight_next;
      fetch_pc_next     = accept ? next_word(fetch_pc_reg) : fetch_pc_reg;
      if (branch_taken) begin
         fetch_pc_next = branch_addr;
      end
`endif
      discard_next = discard_reg;
      if (branch_taken) begin
         discard_next = discard_on_branch;
      end else if (drop) begin
         discard_next = discard_reg - CW'(1);
      end
      // resp_pc tracks the fetch address of the next response that will be kept.
      resp_pc_next = resp_pc_reg;
      if (branch_taken) begin
         resp_pc_next = branch_addr;
      end else if (push) begin
         resp_pc_next = next_word(resp_pc_reg);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN: begin
            if (branch_taken && discard_on_branch != '0) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (branch_taken) begin
               state_next = (discard_on_branch != '0) ? DRAIN : RUN;
            end else if (drop && discard_reg == CW'(1)) begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      push = 1'b0;
      drop = 1'b0;
      case (state_reg)
         RUN:     push = imem_rvalid && !branch_taken;
         DRAIN:   drop = imem_rvalid;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg  <= RESET_PC;
         resp_pc_reg   <= RESET_PC;
         in_flight_reg <= '0;
         discard_reg   <= '0;
      end else begin
         fetch_pc_reg  <= fetch_pc_next;
         resp_pc_reg   <= resp_pc_next;
         in_flight_reg <= in_flight_next;
         discard_reg   <= discard_next;
      end
   end

   assign fifo_din = '{pc: next_word(resp_pc_reg), instr: imem_rdata};

   if_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (branch_taken),
      .din   (fifo_din),
      .dout  (fifo_head),
      .count (fifo_count)
   );

   // Redirect beats freeze; an empty FIFO without freeze turns the outputs into a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 1'b0;
         pc_reg    <= '0;
         instr_reg <= BUBBLE_INSTR;
      end else if (branch_taken) begin
         valid_reg <= 1'b0;
         instr_reg <= BUBBLE_INSTR;
      end else if (pop) begin
         valid_reg <= 1'b1;
         pc_reg    <= fifo_head.pc;
         instr_reg <= fifo_head.instr;
      end else if (!freeze) begin
         valid_reg <= 1'b0;
         instr_reg <= BUBBLE_INSTR;
      end
   end

   assign valid       = valid_reg;
   assign pc          = pc_reg;
   assign instruction = instr_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic against an
// in-order memory model and an instruction-stream reference.
module tb_if_fetch_stage;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] BUB      = 32'hF000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic        valid;

   always #5 clk = ~clk;

   if_fetch_stage #(
      .DEPTH        (DEPTH),
      .RESET_PC     (RESET_PC),
      .BUBBLE_INSTR (BUB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .pc           (pc),
      .instruction  (instruction),
      .valid        (valid)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       memq[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          new_instr = 0;
   int          lat_min = 1;
   int          lat_max = 1;

   logic        rst_cmd = 1'b1;
   logic        freeze_cmd = 1'b0;
   logic        branch_cmd = 1'b0;
   logic        ready_cmd = 1'b1;
   logic [31:0] baddr_cmd = '0;

   // Reference state: expected next fetch address, next instruction pc, and shown outputs.
   logic [31:0] exp_addr = RESET_PC;
   logic [31:0] exp_pc   = RESET_PC + 32'd4;
   logic        m_valid  = 1'b0;
   logic [31:0] m_pc     = '0;
   logic [31:0] m_instr  = BUB;

   logic        p_rst = 1'b1;
   logic        p_branch = 1'b0;
   logic [31:0] p_baddr = '0;
   logic        p_freeze = 1'b0;
   logic        p_req = 1'b0;
   logic        p_ready = 1'b0;
   logic        o_req = 1'b0;
   logic [31:0] o_addr = '0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      if (p_rst) begin
         check_val("rst_valid", valid, 0);
         check_val("rst_instr", instruction, BUB);
         check_val("rst_pc", pc, 0);
         m_valid = 1'b0; m_pc = '0; m_instr = BUB;
         exp_pc = RESET_PC + 32'd4;
      end else if (p_branch) begin
         check_val("br_valid", valid, 0);
         check_val("br_instr", instruction, BUB);
         m_valid = 1'b0; m_instr = BUB;
         exp_pc = p_baddr + 32'd4;
      end else if (p_freeze && m_valid) begin
         check_val("frz_valid", valid, 1);
         check_val("frz_pc", pc, m_pc);
         check_val("frz_instr", instruction, m_instr);
      end else if (valid) begin
         check_val("seq_pc", pc, exp_pc);
         check_val("seq_instr", instruction, exp_pc - 32'd4);
         $display("fetch cycle=%0d pc=%h instr=%h", cyc, pc, instruction);
         m_valid = 1'b1; m_pc = exp_pc; m_instr = exp_pc - 32'd4;
         exp_pc = exp_pc + 32'd4;
         new_instr++;
      end else begin
         check_val("bub_instr", instruction, BUB);
         check_val("bub_pc", pc, m_pc);
         m_valid = 1'b0;
      end
   endtask

   task automatic drive();
      rst          = rst_cmd;
      freeze       = freeze_cmd;
      branch_taken = branch_cmd;
      branch_addr  = baddr_cmd;
      imem_ready   = ready_cmd;
      imem_rvalid  = 1'b0;
      imem_rdata   = $urandom;
      if (!rst_cmd && memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memq[0].addr;
         void'(memq.pop_front());
      end
   endtask

   task automatic observe();
      mreq_t e;
      o_req  = imem_req;
      o_addr = imem_addr;
      if (rst_cmd) begin
         check_val("rst_req", imem_req, 0);
         memq.delete();
         exp_addr = RESET_PC;
      end else begin
         if (branch_cmd) begin
`ifndef IF_BRANCH_BYPASS_EN
            check_val("br_req", imem_req, 0);
`endif
            exp_addr = baddr_cmd;
         end
         if (p_req && !p_ready && !p_rst && !branch_cmd) begin
            check_val("hold_req", imem_req, 1);
         end
         if (imem_req) begin
            check_val("req_addr", imem_addr, exp_addr);
         end
         if (imem_req && imem_ready) begin
            e.addr = imem_addr;
            e.due  = cyc + $urandom_range(lat_max, lat_min);
            memq.push_back(e);
            exp_addr = exp_addr + 32'd4;
         end
         check_val("credit_cap", 32'(memq.size() <= DEPTH), 1);
      end
      p_req    = imem_req;
      p_ready  = imem_ready;
      p_rst    = rst_cmd;
      p_branch = branch_cmd;
      p_baddr  = baddr_cmd;
      p_freeze = freeze_cmd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_outputs();
      drive();
      #1;
      observe();
      cyc++;
   endtask

   task automatic wait_first(input logic [31:0] want);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (valid) seen = 1'b1;
      end
      check_val("redir_seen", 32'(seen), 1);
      check_val("redir_pc", pc, want);
      check_val("redir_instr", instruction, want - 32'd4);
   endtask

   initial begin
      int start_cnt;
      drive();

      // Reset held two cycles, then first request at RESET_PC.
      step();
      step();
      rst_cmd = 1'b0;
      step();
      check_val("start_req", o_req, 1);
      check_val("start_addr", o_addr, RESET_PC);

      // Single-cycle memory: one instruction per cycle after warm-up.
      for (int i = 0; i < 12; i++) begin
         step();
         if (i >= 2) check_val("thru_valid", valid, 1);
      end

      // Freeze while valid: outputs hold, requests stop at the cap.
      freeze_cmd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 3) check_val("frz_req", o_req, 0);
      end
      freeze_cmd = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // Redirect with two stale requests in flight.
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && memq.size() != 2; i++) step();
      check_val("inflight2", 32'(memq.size()), 2);
      branch_cmd = 1'b1; baddr_cmd = 32'h100;
      step();
      branch_cmd = 1'b0;
      wait_first(32'h104);

      // Redirect and freeze in the same cycle.
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 6; i++) step();
      freeze_cmd = 1'b1; branch_cmd = 1'b1; baddr_cmd = 32'h200;
      step();
      freeze_cmd = 1'b0; branch_cmd = 1'b0;
      wait_first(32'h204);

      // Memory not ready for five cycles: outputs drain, request held.
      for (int i = 0; i < 6; i++) step();
      ready_cmd = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check_val("stall_valid", valid, 0);
      check_val("stall_req", o_req, 1);
      ready_cmd = 1'b1;
      for (int i = 0; i < 10; i++) step();

      // Random traffic.
      lat_min = 1; lat_max = 4;
      start_cnt = new_instr;
      for (int i = 0; i < 3000; i++) begin
         rst_cmd    = ($urandom_range(99) == 0);
         freeze_cmd = ($urandom_range(4) == 0);
         branch_cmd = !rst_cmd && ($urandom_range(24) == 0);
         baddr_cmd  = $urandom & 32'hFFFF_FFFC;
         ready_cmd  = ($urandom_range(3) != 0);
         step();
      end
      check_val("rand_live", 32'((new_instr - start_cnt) > 100), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
